regfile_8x16: RTL and testbench
===============================

REGFILE_8X16 -- requirements
Module: regfile_8x16

Interface
REQ-001 Parameter: DATA_W, 16, register and read/write data width.
REQ-002 Parameter: NREGS, 8, number of registers; address width is clog2(NREGS) = 3.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: we_in  input  1  write request for the current cycle.
REQ-006 Port: waddr_in  input  3  write register index.
REQ-007 Port: wdata_in  input  16  write data.
REQ-008 Port: raddr0_in  input  3  read port 0 index.
REQ-009 Port: raddr1_in  input  3  read port 1 index.
REQ-010 Port: rdata0_out  output  16  read port 0 data; drives the downstream 2:1 operand mux d0 input.
REQ-011 Port: rdata1_out  output  16  read port 1 data; drives the downstream 2:1 operand mux d1 input.
REQ-012 Port: clr_in  input  1  single-cycle request to zero the register file.
REQ-013 Port: busy_out  output  1  high while a clear sequence is in progress.

Function
REQ-014 Reads are combinational: rdata0_out = R[raddr0_in], rdata1_out = R[raddr1_in], zero clock latency.
REQ-015 R0 reads as 16'h0000 always; writes addressed to R0 are discarded.
REQ-016 A write is accepted when we_in=1, busy_out=0 and clr_in=0; R[waddr_in] takes wdata_in at that rising edge.
REQ-017 State machine has two states: IDLE and CLEARING; busy_out=1 exactly in CLEARING.
REQ-018 IDLE -> CLEARING on a rising edge with clr_in=1; clear index counter loads 1.
REQ-019 In CLEARING, each edge zeroes R[counter] and increments counter; after R7 is zeroed state returns to IDLE; busy_out is high for exactly 7 cycles.
REQ-020 Counter wraps never: CLEARING exits when counter=7 is processed, counter returns to 0.
REQ-021 clr_in and we_in both high in IDLE: clear has priority, write is dropped.
REQ-022 clr_in while in CLEARING is ignored; sequence is not restarted or extended.
REQ-023 we_in while in CLEARING is dropped with no side effect; no queuing.
REQ-024 Reads during CLEARING return current contents: already-cleared registers read 0, others hold old values.
REQ-025 Register array contents are held indefinitely when no write or clear acts on them.

Reset
REQ-026 rst_n=0 immediately forces all registers to 0, state to IDLE, counter to 0, busy_out to 0, independent of clk.
REQ-027 Reset asserted mid-CLEARING aborts the sequence; after release block is IDLE with all registers 0.
REQ-028 After reset release, first write is accepted at the first rising edge with rst_n=1.

Configuration
REQ-029 Macro MYCPU_RF_BYPASS_EN defined: when a write is accepted this cycle and raddrN_in equals waddr_in (nonzero), rdataN_out shows wdata_in combinationally in the same cycle.
REQ-030 Macro MYCPU_RF_BYPASS_EN undefined: no forwarding; rdataN_out shows the pre-write value until the write edge.
REQ-031 Bypass never applies to R0, to dropped writes, or during CLEARING.

Verification
REQ-032 Reset then read all 8 addresses on both ports -> all read 16'h0000, busy_out=0.
REQ-033 Write R3=16'hA5A5, R5=16'h1234 then read raddr0=3, raddr1=5 -> rdata0=16'hA5A5, rdata1=16'h1234; write R0=16'hFFFF -> R0 reads 0.
REQ-034 Same cycle write R2=16'hBEEF with raddr0=2 -> 16'hBEEF same cycle with MYCPU_RF_BYPASS_EN, old value (0) without it; 16'hBEEF next cycle in both builds.
REQ-035 Fill R1..R7 with 16'h0001..16'h0007, pulse clr_in -> busy_out high 7 cycles; after cycle k R1..Rk read 0, rest unchanged; write R4=16'h5555 in cycle 3 dropped; all 0 at end.
REQ-036 clr_in and we_in (R6=16'h7777) same edge -> write dropped, R6 reads 0 after clear; second clr_in pulse mid-clear does not lengthen busy_out.
REQ-037 Assert rst_n=0 between clock edges during CLEARING cycle 4 -> busy_out falls immediately, all reads 0 after release, next write accepted.

Source files
------------

// File: rtl/regfile_8x16.sv
// ---------------------------------------------------------------------------
// regfile_8x16
//
// Purpose:
//   Eight-entry, 16-bit register file with two combinational read ports and
//   one synchronous write port. R0 is hard-wired to zero. A single-cycle
//   clr_in request starts a sequence that zeroes R1..R7, one register per
//   clock, while busy_out is high.
//
// Optional feature:
//   MYCPU_RF_BYPASS_EN - when defined, a write accepted in the current cycle
//   is forwarded combinationally to any read port addressing the same
//   (nonzero) register. When undefined, reads show the pre-write value until
//   the write edge.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   we_in       in   1   write request
//   waddr_in    in   3   write register index
//   wdata_in    in   16  write data
//   raddr0_in   in   3   read port 0 index
//   raddr1_in   in   3   read port 1 index
//   rdata0_out  out  16  read port 0 data
//   rdata1_out  out  16  read port 1 data
//   clr_in      in   1   request to zero the register file
//   busy_out    out  1   high while the clear sequence runs
//
// Write acceptance: a write takes effect at a rising edge only when
// we_in=1, the block is IDLE and clr_in=0. There is no back-pressure;
// a write that is not accepted is dropped, never queued.
// ---------------------------------------------------------------------------
module regfile_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_in,
    input  logic [AW-1:0]     waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [AW-1:0]     raddr0_in,
    input  logic [AW-1:0]     raddr1_in,
    output logic [DATA_W-1:0] rdata0_out,
    output logic [DATA_W-1:0] rdata1_out,
    input  logic              clr_in,
    output logic              busy_out
);

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_accept;

    // A clear request in the same cycle wins over the write.
    assign wr_accept = we_in && (state_q == IDLE) && !clr_in && (waddr_in != '0);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;

        case (state_q)
            IDLE: begin
                if (clr_in) begin
                    state_d = CLEARING;
                    cnt_d   = AW'(1);   // R0 is already zero; start at R1
                end else if (wr_accept) begin
                    regs_d[waddr_in] = wdata_in;
                end
            end
            CLEARING: begin
                // clr_in and we_in are ignored here: the sequence runs a
                // fixed NREGS-1 cycles and writes are dropped.
                regs_d[cnt_q] = '0;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        regs_d[0] = '0;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign busy_out = (state_q == CLEARING);

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
`ifdef MYCPU_RF_BYPASS_EN
    // wr_accept already excludes R0, busy cycles and clear requests, so the
    // forward path can only show data that will actually be written.
    assign rdata0_out = (wr_accept && (raddr0_in == waddr_in)) ? wdata_in : regs_q[raddr0_in];
    assign rdata1_out = (wr_accept && (raddr1_in == waddr_in)) ? wdata_in : regs_q[raddr1_in];
`else
    assign rdata0_out = regs_q[raddr0_in];
    assign rdata1_out = regs_q[raddr1_in];
`endif

endmodule

// File: tb/tb_regfile_8x16.sv
// ---------------------------------------------------------------------------
// tb_regfile_8x16
//
// Self-checking bench for regfile_8x16. Inputs change on the falling edge,
// outputs are sampled 1 ns later (well before the next rising edge).
// Honours MYCPU_RF_BYPASS_EN for same-cycle forwarding expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/10ps
module tb_regfile_8x16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_in;
    logic [2:0]  waddr_in;
    logic [15:0] wdata_in;
    logic [2:0]  raddr0_in;
    logic [2:0]  raddr1_in;
    logic [15:0] rdata0_out;
    logic [15:0] rdata1_out;
    logic        clr_in;
    logic        busy_out;

    always #5 clk = ~clk;

    regfile_8x16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_in      (we_in),
        .waddr_in   (waddr_in),
        .wdata_in   (wdata_in),
        .raddr0_in  (raddr0_in),
        .raddr1_in  (raddr1_in),
        .rdata0_out (rdata0_out),
        .rdata1_out (rdata1_out),
        .clr_in     (clr_in),
        .busy_out   (busy_out)
    );

    // ---------------- reference model ----------------
    // Register contents as an array; a pending clear is a queue of the
    // register indices still to be zeroed, one popped per clock edge.
    logic [15:0] m_rf [8];
    int          clr_q [$];

    int checks = 0;
    int errors = 0;
    logic busy_seen;

    function automatic logic m_busy();
        return clr_q.size() != 0;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] ra, input logic we,
                                           input logic [2:0] wa, input logic [15:0] wd,
                                           input logic clr);
        logic [15:0] v;
        v = (ra == 3'd0) ? 16'h0000 : m_rf[ra];
`ifdef MYCPU_RF_BYPASS_EN
        if (!m_busy() && !clr && we && wa != 3'd0 && ra == wa) v = wd;
`endif
        return v;
    endfunction

    task automatic m_edge(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                          input logic clr);
        int idx;
        if (m_busy()) begin
            idx = clr_q.pop_front();
            m_rf[idx] = 16'h0000;
        end else if (clr) begin
            for (int i = 1; i < 8; i++) clr_q.push_back(i);
        end else if (we && wa != 3'd0) begin
            m_rf[wa] = wd;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        clr_q.delete();
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive, check outputs against the supplied expectation,
    // advance the model at the rising edge, return at the falling edge.
    task automatic tick(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra0, input logic [2:0] ra1, input logic clr,
                        input logic [15:0] e0, input logic [15:0] e1, input logic eb,
                        input string name);
        we_in = we; waddr_in = wa; wdata_in = wd;
        raddr0_in = ra0; raddr1_in = ra1; clr_in = clr;
        #1;
        busy_seen = busy_out;
        chk({name, ".rdata0"}, rdata0_out, e0);
        chk({name, ".rdata1"}, rdata1_out, e1);
        chk({name, ".busy"}, {15'd0, busy_out}, {15'd0, eb});
        @(posedge clk);
        m_edge(we, wa, wd, clr);
        @(negedge clk);
    endtask

    task automatic mtick(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra0, input logic [2:0] ra1, input logic clr,
                         input string name);
        tick(we, wa, wd, ra0, ra1, clr,
             m_read(ra0, we, wa, wd, clr), m_read(ra1, we, wa, wd, clr), m_busy(), name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic        clr;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        eb;
    } vec_t;

    vec_t vecs [6];

    int busy_cnt;

    initial begin
        vecs[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd0, 3'd1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd2, 1'b0, 16'hA5A5, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd3, 3'd5, 1'b0, 16'hA5A5, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, 1'b0, 16'h0000, 16'h1234, 1'b0};
        vecs[4] = '{1'b1, 3'd7, 16'h0F0F, 3'd5, 3'd3, 1'b0, 16'h1234, 16'hA5A5, 1'b0};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 1'b0, 16'h0F0F, 16'h0000, 1'b0};

        // ---- reset ----
        rst_n = 1'b0; we_in = 1'b0; waddr_in = 3'd0; wdata_in = 16'h0;
        raddr0_in = 3'd0; raddr1_in = 3'd0; clr_in = 1'b0;
        m_reset();
        #1;
        chk("reset.busy", {15'd0, busy_out}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- all addresses read zero after reset ----
        for (int i = 0; i < 8; i++)
            tick(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, 16'h0000, 16'h0000, 1'b0, "rst_read");

        // ---- table: basic writes, R0 discard ----
        for (int i = 0; i < 6; i++)
            tick(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1, vecs[i].clr,
                 vecs[i].e0, vecs[i].e1, vecs[i].eb, $sformatf("vec%0d", i));

        // ---- same-cycle write/read of R2 ----
`ifdef MYCPU_RF_BYPASS_EN
        tick(1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd3, 1'b0, 16'hBEEF, 16'hA5A5, 1'b0, "byp_same");
`else
        tick(1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd3, 1'b0, 16'h0000, 16'hA5A5, 1'b0, "byp_same");
`endif
        tick(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, "byp_next");

        // ---- fill R1..R7 then clear, dropped write in cycle 3 ----
        for (int i = 1; i < 8; i++)
            mtick(1'b1, 3'(i), 16'(i), 3'd0, 3'(i), 1'b0, "fill");
        mtick(1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 1'b1, "clr_start");
        busy_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            // ra1 = k is still uncleared in busy cycle k, ra0 = k-1 was cleared
            mtick(k == 3, 3'd4, 16'h5555, 3'(k - 1), 3'(k), 1'b0, $sformatf("clr_c%0d", k));
            if (busy_seen) busy_cnt++;
        end
        chk("clr_busy_cycles", 16'(busy_cnt), 16'd7);
        mtick(1'b0, 3'd0, 16'h0, 3'd4, 3'd7, 1'b0, "clr_done");

        // ---- clr+we same edge, second clr mid-sequence ----
        mtick(1'b1, 3'd6, 16'h1111, 3'd0, 3'd0, 1'b0, "r6_pre");
        mtick(1'b1, 3'd6, 16'h7777, 3'd6, 3'd0, 1'b1, "clr_we");
        busy_cnt = 0;
        for (int k = 1; k <= 12 && (k == 1 || busy_seen); k++) begin
            mtick(1'b0, 3'd0, 16'h0, 3'd6, 3'(k & 7), k == 3, $sformatf("clr2_c%0d", k));
            if (busy_seen) busy_cnt++;
        end
        chk("clr2_busy_cycles", 16'(busy_cnt), 16'd7);
        tick(1'b0, 3'd0, 16'h0, 3'd6, 3'd1, 1'b0, 16'h0000, 16'h0000, 1'b0, "r6_after");

        // ---- reset during clear cycle 4 ----
        for (int i = 1; i < 8; i++)
            mtick(1'b1, 3'(i), 16'hC000 + 16'(i), 3'd0, 3'd0, 1'b0, "fill2");
        mtick(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, "clr3_start");
        for (int k = 1; k <= 3; k++)
            mtick(1'b0, 3'd0, 16'h0, 3'd5, 3'd7, 1'b0, $sformatf("clr3_c%0d", k));
        rst_n = 1'b0;
        #0.5;
        chk("midrst.busy", {15'd0, busy_out}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            raddr0_in = 3'(i); raddr1_in = 3'(7 - i);
            #0.3;
            chk("midrst.rd0", rdata0_out, 16'h0000);
            chk("midrst.rd1", rdata1_out, 16'h0000);
        end
        m_reset();
        rst_n = 1'b1;
        #0.5;
        tick(1'b1, 3'd4, 16'h5555, 3'd5, 3'd7, 1'b0, 16'h0000, 16'h0000, 1'b0, "post_rst_wr");
        tick(1'b0, 3'd0, 16'h0, 3'd4, 3'd6, 1'b0, 16'h5555, 16'h0000, 1'b0, "post_rst_rd");

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++)
            mtick($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0, "rand");

        // ---- drain any clear, then sweep ----
        for (int n = 0; n < 10; n++)
            mtick(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, "drain");
        for (int i = 0; i < 8; i++)
            mtick(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, "sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
